leak_test_sequencer: RTL
========================

LEAK_TEST_SEQUENCER -- requirements
Module: leak_test_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width, legal range 1..8.
REQ-002 SHALL have parameter NUM_TRIALS, default 16: trials per run, legal range 1..65535.
REQ-003 SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles per trial, legal range 2..65535.
REQ-004 SHALL have parameter SEED, default 32'hACE1_1234: nonzero LFSR seed.
REQ-005 SHALL have ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- run  input  1  level request to execute one campaign.
- timingLeak  input  1  mismatch flag from the two-copy multiplier tester.
- timingLeakDone  input  1  either multiplier copy finished.
- start  output  1  one-cycle start pulse to the tester.
- multiplierOne, multiplicandOne, multiplierTwo, multiplicandTwo  output  WIDTH each  operands.
- trialCount  output  16  completed trials.
- leakCount  output  16  trials flagged as leaking.
- timeoutFlag  output  1  sticky, set when any trial timed out.
- busy  output  1  high in every state except IDLE and FINISH.
- done  output  1  campaign complete.

Function
REQ-006 SHALL implement the FSM states IDLE, LOAD, START, WAIT, CHECK, FINISH.
REQ-007 IDLE: on run=1, SHALL clear trialCount, leakCount, timeoutFlag, load LFSR with SEED, go to LOAD.
REQ-008 LFSR SHALL be 32-bit Fibonacci, taps 32,22,2,1 (XOR), shifted exactly once per LOAD.
REQ-009 LOAD (1 cycle): operands SHALL register from post-shift LFSR: multiplierOne=[W-1:0], multiplicandOne=[2W-1:W], multiplierTwo=[3W-1:2W], multiplicandTwo=[4W-1:3W]; next state START.
REQ-010 START (1 cycle): start SHALL be 1 only in this state; next state WAIT.
REQ-011 Operands SHALL remain stable from the cycle after LOAD through CHECK.
REQ-012 WAIT: the cycle counter SHALL clear on entry and increment each cycle; timingLeakDone SHALL be ignored in the first WAIT cycle.
REQ-013 WAIT: on timingLeakDone=1, SHALL sample timingLeak into a leak bit and go to CHECK.
REQ-014 WAIT: if the counter reaches TIMEOUT with no done, SHALL set leak bit=1 and timeoutFlag=1, then go to CHECK.
REQ-015 If done and timeout occur in the same cycle, SHALL treat it as done and SHALL NOT set timeoutFlag.
REQ-016 CHECK (1 cycle): trialCount SHALL increment; leakCount SHALL increment if leak bit=1, saturating at 16'hFFFF.
REQ-017 CHECK: SHALL go to FINISH if the new trialCount equals NUM_TRIALS, else to LOAD.
REQ-018 FINISH: done SHALL be 1 and counters held; on run=0, SHALL go to IDLE (done=0); counters SHALL hold until the next run.
REQ-019 run deassertion outside IDLE and FINISH SHALL be ignored; a campaign always completes.
REQ-020 Minimum trial length SHALL be 5 cycles (LOAD, START, 2 WAIT, CHECK).

Reset
REQ-021 rst=0 at a clock edge SHALL force IDLE, start=0, operands=0, trialCount=0, leakCount=0, timeoutFlag=0, busy=0, done=0, LFSR=SEED; this SHALL take effect from any state, including mid-WAIT.

Verification
REQ-022 Matched copies, done after 3 WAIT cycles with timingLeak=0, NUM_TRIALS=4 -> done=1, trialCount=4, leakCount=0, timeoutFlag=0, exactly 4 start pulses.
REQ-023 timingLeak=1 on trials 2 and 3 of 4 -> leakCount=2, trialCount=4.
REQ-024 timingLeakDone tied to 0, TIMEOUT=8, NUM_TRIALS=2 -> each trial spends 8 WAIT cycles; leakCount=2, timeoutFlag=1.
REQ-025 timingLeakDone=1 in the first WAIT cycle only -> ignored; trial ends at TIMEOUT as a leak.
REQ-026 rst=0 during WAIT of trial 3 -> next cycle IDLE with all outputs 0; run=1 restarts with the operands identical to trial 1 of the previous run.
REQ-027 Operand check: first LOAD after SEED equals the golden-model LFSR shift; operands are constant from START through CHECK.

Source files
------------

// File: rtl/leak_test_sequencer.sv
// leak_test_sequencer
//   Drives a two-copy multiplier timing-leak tester through a campaign of
//   NUM_TRIALS trials. Each trial loads four pseudo-random operands from a
//   32-bit LFSR, pulses start, waits for the tester to finish (or times out)
//   and accumulates the trial and leak counts.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-low reset
//   run             level request to execute one campaign
//   timingLeak      mismatch flag from the tester
//   timingLeakDone  either multiplier copy finished
//   start           one-cycle start pulse to the tester
//   multiplierOne / multiplicandOne / multiplierTwo / multiplicandTwo
//                   operands, stable from START through CHECK
//   trialCount      completed trials
//   leakCount       trials flagged as leaking (saturating)
//   timeoutFlag     sticky, set when any trial timed out
//   busy            high in every state except IDLE and FINISH
//   done            campaign complete
module leak_test_sequencer #(
    parameter int          WIDTH      = 8,
    parameter int          NUM_TRIALS = 16,
    parameter int          TIMEOUT    = 64,
    parameter logic [31:0] SEED       = 32'hACE1_1234
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             timingLeak,
    input  logic             timingLeakDone,
    output logic             start,
    output logic [WIDTH-1:0] multiplierOne,
    output logic [WIDTH-1:0] multiplicandOne,
    output logic [WIDTH-1:0] multiplierTwo,
    output logic [WIDTH-1:0] multiplicandTwo,
    output logic [15:0]      trialCount,
    output logic [15:0]      leakCount,
    output logic             timeoutFlag,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        CHECK  = 3'd4,
        FINISH = 3'd5
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [31:0] lfsr;
    logic [31:0] lfsrNext;
    logic [15:0] waitCnt;
    logic        leakBit;
    logic        waitDone;
    logic        waitTimeout;
    logic        lastTrial;

    // Fibonacci LFSR, taps 32,22,2,1.
    assign lfsrNext = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

    // waitCnt is 0 in the first WAIT cycle, so a done there is ignored.
    // Timeout fires in WAIT cycle number TIMEOUT; done wins a tie.
    assign waitDone    = (waitCnt != 16'd0) && timingLeakDone;
    assign waitTimeout = (waitCnt == 16'(TIMEOUT - 1));
    assign lastTrial   = ((trialCount + 16'd1) == 16'(NUM_TRIALS));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (run) nextState = LOAD;
            LOAD:    nextState = START;
            START:   nextState = WAIT;
            WAIT:    if (waitDone || waitTimeout) nextState = CHECK;
            CHECK:   nextState = lastTrial ? FINISH : LOAD;
            FINISH:  if (!run) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        start = (state == START);
        busy  = (state != IDLE) && (state != FINISH);
        done  = (state == FINISH);
    end

    // Datapath: LFSR, operands, wait counter, trial/leak bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr            <= SEED;
            multiplierOne   <= '0;
            multiplicandOne <= '0;
            multiplierTwo   <= '0;
            multiplicandTwo <= '0;
            trialCount      <= '0;
            leakCount       <= '0;
            timeoutFlag     <= 1'b0;
            waitCnt         <= '0;
            leakBit         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        trialCount  <= '0;
                        leakCount   <= '0;
                        timeoutFlag <= 1'b0;
                        lfsr        <= SEED;
                    end
                end
                LOAD: begin
                    // Operands come from the post-shift value so the first
                    // trial already uses a stepped LFSR.
                    lfsr            <= lfsrNext;
                    multiplierOne   <= lfsrNext[WIDTH-1:0];
                    multiplicandOne <= lfsrNext[2*WIDTH-1:WIDTH];
                    multiplierTwo   <= lfsrNext[3*WIDTH-1:2*WIDTH];
                    multiplicandTwo <= lfsrNext[4*WIDTH-1:3*WIDTH];
                end
                START: begin
                    waitCnt <= '0;
                end
                WAIT: begin
                    waitCnt <= waitCnt + 16'd1;
                    if (waitDone) begin
                        leakBit <= timingLeak;
                    end else if (waitTimeout) begin
                        leakBit     <= 1'b1;
                        timeoutFlag <= 1'b1;
                    end
                end
                CHECK: begin
                    trialCount <= trialCount + 16'd1;
                    if (leakBit && (leakCount != 16'hFFFF)) begin
                        leakCount <= leakCount + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
